// File: rtl/frv_pipeline_fetch.sv
// Instruction fetch stage: one outstanding memory request, a 2-entry buffer
// toward decode, and redirect handling with stale-response dropping.
module frv_pipeline_fetch #(
  parameter logic [31:0] FRV_PC_RESET = 32'h8000_0000
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cf_req,
  input  logic [31:0] cf_target,
  output logic        cf_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_recv,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic        s1_valid,
  output logic [31:0] s1_data,
  output logic [31:0] s1_pc,
  output logic        s1_error,
  input  logic        s1_busy
);

  logic [29:0] fetch_word_r;
  logic [29:0] req_word_r;
  logic        outstanding_r;
  logic        drop_r;
  logic        hold_r;
  logic [31:0] fifo_data_r [2];
  logic [29:0] fifo_word_r [2];
  logic        fifo_err_r  [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;

  logic        issue_s;
  logic        stall_s;
  logic        grant_s;
  logic        push_s;
  logic        pop_s;
  logic        outstanding_nxt_s;
  logic [29:0] target_word_s;
  logic        unused_target_s;

  assign target_word_s   = cf_target[31:2];
  assign unused_target_s = ^cf_target[1:0];

  assign imem_addr = {fetch_word_r, 2'b00};
  assign s1_valid  = (count_r != 2'd0);
  assign s1_data   = fifo_data_r[rd_ptr_r];
  assign s1_pc     = {fifo_word_r[rd_ptr_r], 2'b00};
  assign s1_error  = fifo_err_r[rd_ptr_r];

  // Request issue and handshake decode; a pending redirect blocks new issue,
  // so cf_ack never depends on itself through imem_req.
  always_comb begin
    issue_s           = 1'b0;
    imem_req          = 1'b0;
    if (!outstanding_r && (count_r < 2'd2) && !hold_r && !cf_req) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (g_resetn) begin
      imem_req = hold_r || issue_s;
    end else begin
      imem_req = 1'b0;
    end
    stall_s           = imem_req && !imem_gnt;
    grant_s           = imem_req && imem_gnt;
    cf_ack            = g_resetn && cf_req && !stall_s;
    outstanding_nxt_s = (outstanding_r && !imem_recv) || grant_s;
    push_s            = imem_recv && !drop_r && !cf_ack;
    pop_s             = (count_r != 2'd0) && !s1_busy;
  end

  // Fetch address, transaction tracking and buffer pointers.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fetch_word_r  <= FRV_PC_RESET[31:2];
      req_word_r    <= 30'd0;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
      hold_r        <= 1'b0;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      hold_r        <= stall_s;
      outstanding_r <= outstanding_nxt_s;
      if (grant_s) begin
        req_word_r <= fetch_word_r;
      end
      if (cf_ack) begin
        fetch_word_r <= target_word_s;
      end else if (grant_s) begin
        fetch_word_r <= fetch_word_r + 30'd1;
      end
      // A response still in flight after a redirect belongs to the old stream.
      if (cf_ack) begin
        drop_r <= outstanding_nxt_s;
      end else if (imem_recv) begin
        drop_r <= 1'b0;
      end
      if (cf_ack) begin
        rd_ptr_r <= 1'b0;
        wr_ptr_r <= 1'b0;
        count_r  <= 2'd0;
      end else begin
        case ({push_s, pop_s})
          2'b10: begin
            wr_ptr_r <= ~wr_ptr_r;
            count_r  <= count_r + 2'd1;
          end
          2'b01: begin
            rd_ptr_r <= ~rd_ptr_r;
            count_r  <= count_r - 2'd1;
          end
          2'b11: begin
            wr_ptr_r <= ~wr_ptr_r;
            rd_ptr_r <= ~rd_ptr_r;
          end
          default: begin
            count_r <= count_r;
          end
        endcase
      end
    end
  end

  // Buffer payload; entries are only meaningful while counted by count_r.
  always_ff @(posedge g_clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= imem_rdata;
      fifo_word_r[wr_ptr_r] <= req_word_r;
      fifo_err_r[wr_ptr_r]  <= imem_error;
    end
  end

endmodule

// File: tb/tb_frv_pipeline_fetch.sv
// Bench for frv_pipeline_fetch: cycle table of directed cases, then a
// randomized run against a memory model and an in-order fetch-stream model.
module tb_frv_pipeline_fetch;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        cf_req;
  logic [31:0] cf_target;
  logic        cf_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_recv;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        s1_valid;
  logic [31:0] s1_data;
  logic [31:0] s1_pc;
  logic        s1_error;
  logic        s1_busy;

  frv_pipeline_fetch #(.FRV_PC_RESET(32'h8000_0000)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .cf_req(cf_req), .cf_target(cf_target),
    .cf_ack(cf_ack), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_recv(imem_recv), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_pc(s1_pc), .s1_error(s1_error),
    .s1_busy(s1_busy)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        rst_n, cf, gnt, recv, err, busy;
    logic [31:0] tgt, rdata;
    logic        x_req, x_ack, x_valid, x_err;
    logic [31:0] x_addr, x_pc, x_data;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pops = 0;

  // memory / stream model state
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_cnt = 0;
  int          gnt_pct = 100;
  int          lat_max = 1;
  logic [31:0] exp_pc = 32'h8000_0000;
  logic        held_prev = 1'b0;
  logic [31:0] held_addr = 32'd0;
  logic        snap_req, snap_ack, snap_valid;
  logic [31:0] snap_addr, snap_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[5:2] == 4'd5);
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic row(input logic rst, input logic cf, input logic [31:0] tgt,
                     input logic gnt, input logic recv, input logic [31:0] rd,
                     input logic er, input logic bs, input logic xreq,
                     input logic [31:0] xaddr, input logic xack, input logic xv,
                     input logic [31:0] xpc, input logic [31:0] xdata, input logic xerr);
    vec_t v;
    v.rst_n = rst; v.cf = cf; v.tgt = tgt; v.gnt = gnt; v.recv = recv; v.rdata = rd;
    v.err = er; v.busy = bs; v.x_req = xreq; v.x_addr = xaddr; v.x_ack = xack;
    v.x_valid = xv; v.x_pc = xpc; v.x_data = xdata; v.x_err = xerr;
    tbl.push_back(v);
  endtask

  // One cycle with the behavioural memory responding and the stream model checking.
  task automatic cycle_auto();
    logic ack_exp;
    if (!g_resetn) begin
      mem_pend  = 1'b0;
      imem_recv = 1'b0;
    end else begin
      imem_recv = mem_pend && (mem_cnt == 0);
    end
    imem_rdata = imem_recv ? mem_data(mem_addr) : $urandom;
    imem_error = imem_recv ? mem_err(mem_addr) : 1'b0;
    imem_gnt   = ($urandom_range(99, 0) < gnt_pct);
    @(negedge g_clk);
    snap_req = imem_req; snap_ack = cf_ack; snap_valid = s1_valid;
    snap_addr = imem_addr; snap_pc = s1_pc;
    if (!g_resetn) begin
      check("rst_quiet", {imem_req, cf_ack}, 2'b00);
      exp_pc    = 32'h8000_0000;
      held_prev = 1'b0;
    end else begin
      ack_exp = cf_req && !(imem_req && !imem_gnt);
      check("cf_ack", cf_ack, ack_exp);
      if (held_prev) check("hold_stable", {imem_req, imem_addr}, {1'b1, held_addr});
      if (imem_req) check("single_outstanding", mem_pend, 1'b0);
      if (s1_valid && !s1_busy) begin
        check("stream", {s1_pc, s1_data, s1_error}, {exp_pc, mem_data(exp_pc), mem_err(exp_pc)});
        exp_pc = exp_pc + 32'd4;
        n_pops++;
      end
      if (ack_exp) exp_pc = {cf_target[31:2], 2'b00};
      held_prev = imem_req && !imem_gnt;
      held_addr = imem_addr;
      if (imem_recv) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt = mem_cnt - 1;
      if (imem_req && imem_gnt) begin
        mem_pend = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(lat_max - 1, 0);
      end
    end
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    logic [127:0] got, exp;
    // rst cf tgt gnt recv rdata err busy | req addr ack valid pc data err
    row(0,0,32'h0,0,0,32'h0,0,0, 0,32'h8000_0000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h8000_0000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,1,32'hA000_0000,0,0, 0,32'h8000_0004,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h8000_0004,0,1,32'h8000_0000,32'hA000_0000,0);
    row(1,0,32'h0,1,1,32'hA111_1111,1,0, 0,32'h8000_0008,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h8000_0008,0,1,32'h8000_0004,32'hA111_1111,1);
    row(1,0,32'h0,0,1,32'hA222_2222,0,0, 0,32'h8000_000C,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,0,32'h0,0,0, 1,32'h8000_000C,0,1,32'h8000_0008,32'hA222_2222,0);
    row(1,1,32'h0000_2000,0,0,32'h0,0,0, 1,32'h8000_000C,0,0,32'h0,32'h0,0);
    row(1,1,32'h0000_2000,0,0,32'h0,0,0, 1,32'h8000_000C,0,0,32'h0,32'h0,0);
    row(1,1,32'h0000_2000,0,0,32'h0,0,0, 1,32'h8000_000C,0,0,32'h0,32'h0,0);
    row(1,1,32'h0000_2000,1,0,32'h0,0,0, 1,32'h8000_000C,1,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'hDEAD_0001,0,0, 0,32'h0000_2000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h0000_2000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'hB000_0000,0,0, 0,32'h0000_2004,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,0,32'h0,0,0, 1,32'h0000_2004,0,1,32'h0000_2000,32'hB000_0000,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h0000_2004,0,0,32'h0,32'h0,0);
    row(1,1,32'h0000_1002,0,0,32'h0,0,0, 0,32'h0000_2008,1,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'hDEAD_0002,0,0, 0,32'h0000_1000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h0000_1000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'hC000_0000,0,0, 0,32'h0000_1004,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h0000_1004,0,1,32'h0000_1000,32'hC000_0000,0);
    row(1,1,32'hFFFF_FFFF,0,1,32'hC111_1111,0,0, 0,32'h0000_1008,1,0,32'h0,32'h0,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'hFFFF_FFFC,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'hE000_0000,0,0, 0,32'h0000_0000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,0,32'h0,0,0, 1,32'h0000_0000,0,1,32'hFFFF_FFFC,32'hE000_0000,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h0000_0000,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,1,32'hE111_1111,0,0, 0,32'h0000_0004,0,0,32'h0,32'h0,0);
    row(1,0,32'h0,0,0,32'h0,0,1, 1,32'h0000_0004,0,1,32'h0000_0000,32'hE111_1111,0);
    row(1,0,32'h0,1,0,32'h0,0,1, 1,32'h0000_0004,0,1,32'h0000_0000,32'hE111_1111,0);
    row(1,0,32'h0,0,1,32'hE222_2222,0,1, 0,32'h0000_0008,0,1,32'h0000_0000,32'hE111_1111,0);
    row(1,0,32'h0,1,0,32'h0,0,1, 0,32'h0000_0008,0,1,32'h0000_0000,32'hE111_1111,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 0,32'h0000_0008,0,1,32'h0000_0000,32'hE111_1111,0);
    row(1,0,32'h0,1,0,32'h0,0,0, 1,32'h0000_0008,0,1,32'h0000_0004,32'hE222_2222,0);

    g_resetn = 1'b0; cf_req = 1'b0; cf_target = 32'd0; imem_gnt = 1'b0;
    imem_recv = 1'b0; imem_rdata = 32'd0; imem_error = 1'b0; s1_busy = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;

    foreach (tbl[i]) begin
      g_resetn = tbl[i].rst_n; cf_req = tbl[i].cf; cf_target = tbl[i].tgt;
      imem_gnt = tbl[i].gnt; imem_recv = tbl[i].recv; imem_rdata = tbl[i].rdata;
      imem_error = tbl[i].err; s1_busy = tbl[i].busy;
      @(negedge g_clk);
      got = {imem_req, imem_addr, cf_ack, s1_valid,
             (s1_valid ? {s1_pc, s1_data, s1_error} : 65'd0)};
      exp = {tbl[i].x_req, tbl[i].x_addr, tbl[i].x_ack, tbl[i].x_valid,
             (tbl[i].x_valid ? {tbl[i].x_pc, tbl[i].x_data, tbl[i].x_err} : 65'd0)};
      check($sformatf("vec%0d", i), got, exp);
      @(posedge g_clk);
      #1;
    end

    // Reset while a request is outstanding and a redirect is pending.
    g_resetn = 1'b0; cf_req = 1'b1; cf_target = 32'h0000_4000; s1_busy = 1'b1;
    cycle_auto();
    cf_req = 1'b0;
    cycle_auto();
    g_resetn = 1'b1; gnt_pct = 100; lat_max = 1;

    // Decode stalled: two words buffered, then fetch stops.
    for (int i = 0; i < 10; i++) begin
      cycle_auto();
      if (i == 0) check("post_reset", {snap_valid, snap_req, snap_addr}, {1'b0, 1'b1, 32'h8000_0000});
      if (i >= 4) check("full_stall", {snap_req, snap_valid}, 2'b01);
      if (i == 9) check("full_head", snap_pc, 32'h8000_0000);
    end
    s1_busy = 1'b0;
    cycle_auto();
    check("pop_not_credited", snap_req, 1'b0);
    cycle_auto();
    check("refill", {snap_req, snap_addr}, {1'b1, 32'h8000_0008});

    // Randomized traffic: grant delays, response latency, stalls, redirects.
    gnt_pct = 70; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (cf_req) begin
        if (snap_ack) cf_req = 1'b0;
      end else if ($urandom_range(99, 0) < 4) begin
        cf_req    = 1'b1;
        cf_target = $urandom;
      end
      s1_busy = ($urandom_range(99, 0) < 30);
      cycle_auto();
    end
    check("progress", (n_pops >= 150), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frv_pipeline_fetch.md
FRV_PIPELINE_FETCH -- requirements
Module: frv_pipeline_fetch

Interface
REQ-001 SHALL have parameter FRV_PC_RESET, default 32'h8000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port g_clk, input, 1, global clock.
REQ-003 SHALL have port g_resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port cf_req, input, 1, control flow change request from writeback.
REQ-005 SHALL have port cf_target, input, 32, new fetch address; bits [1:0] ignored.
REQ-006 SHALL have port cf_ack, output, 1, redirect accepted this cycle.
REQ-007 SHALL have port imem_req, output, 1, instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32, word-aligned request address.
REQ-009 SHALL have port imem_gnt, input, 1, request accepted by memory.
REQ-010 SHALL have port imem_recv, input, 1, response valid.
REQ-011 SHALL have port imem_rdata, input, 32, response data.
REQ-012 SHALL have port imem_error, input, 1, response bus error.
REQ-013 SHALL have ports s1_valid (output, 1), s1_data (output, 32), s1_pc (output, 32), s1_error (output, 1), giving the fetched word to decode.
REQ-014 SHALL have port s1_busy, input, 1, decode cannot accept.

Function
REQ-015 SHALL hold fetch_pc register; imem_addr = {fetch_pc[31:2],2'b00}; fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC->0) on imem_req && imem_gnt.
REQ-016 SHALL allow at most 1 outstanding request (granted, response not yet received); memory never asserts imem_recv in the grant cycle.
REQ-017 SHALL use a 2-entry FIFO of {data, pc, error}; s1_valid = FIFO non-empty; s1_* driven from head; pop on s1_valid && !s1_busy.
REQ-018 SHALL start a new request only when: no outstanding request, occupancy + 0 < 2 (pop in same cycle not credited), not held, and cf_req low.
REQ-019 SHALL, once imem_req is asserted without imem_gnt, set hold; while held imem_req stays 1 and imem_addr stays stable until imem_gnt, regardless of cf_req.
REQ-020 SHALL drive cf_ack = cf_req && !(imem_req && !imem_gnt) (combinational; no loop, since unheld imem_req is suppressed by cf_req).
REQ-021 SHALL on cf_ack: fetch_pc <= {cf_target[31:2],2'b00}; FIFO flushed (flush beats same-cycle push/pop); set drop flag if a request is outstanding after this cycle (incl. one granted this cycle).
REQ-022 SHALL on imem_recv with drop set: discard response, clear drop, clear outstanding.
REQ-023 SHALL on imem_recv coinciding with cf_ack: discard response (stale), clear outstanding, leave drop clear.
REQ-024 SHALL otherwise on imem_recv push {imem_rdata, request address, imem_error}; fetch continues after errors.
REQ-025 SHALL guarantee push never occurs into a full FIFO (guaranteed by REQ-018).
REQ-026 SHALL issue the first post-redirect request no earlier than the cycle after cf_ack, once drop/outstanding clear.

Reset
REQ-027 SHALL, while g_resetn=0, force imem_req=0 and cf_ack=0; on the next clock edge set fetch_pc=FRV_PC_RESET, FIFO empty, outstanding=0, drop=0, hold=0.
REQ-028 SHALL, the first cycle after reset release, output s1_valid=0, imem_req=1, imem_addr=FRV_PC_RESET.
REQ-029 SHALL, on reset mid-transaction, discard all state; a late imem_recv in the cycle after reset is memory-model responsibility (bench holds memory in reset too).

Verification
REQ-030 Reset, gnt every request, recv 1 cycle later, s1_busy=0 -> s1_pc sequence 0x80000000, 0x80000004, 0x80000008 with matching data.
REQ-031 s1_busy=1 for 10 cycles -> exactly 2 words buffered, imem_req=0 until a pop; no data lost or reordered.
REQ-032 cf_req with target 0x00001002 while request outstanding -> cf_ack same cycle, old response dropped, next imem_addr=0x00001000, s1_pc=0x00001000.
REQ-033 cf_req while imem_req held with gnt=0 for 3 cycles -> cf_ack=0 until gnt cycle, addr stable, granted response then dropped.
REQ-034 imem_error=1 on response at 0x80000004 -> s1_error=1 for that entry only; fetch continues at 0x80000008.
REQ-035 fetch_pc=0xFFFFFFFC granted -> next imem_addr=0x00000000.
